ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register.
- Contains:
  - ALU control decode
  - integrated forwarding unit (from EX/MEM and MEM/WB)
  - operand muxes and 32-bit ALU
  - branch comparator and branch-target adder
- Resolves branches in EX and drives the PC redirect combinationally to IF and the hazard unit.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- read_data1_IDEX  in  32  rs1 value from the register file
- read_data2_IDEX  in  32  rs2 value from the register file
- PC_IDEX  in  32  PC of the instruction in EX
- imm_IDEX  in  32  sign-extended immediate
- instruc_IDEX  in  32  full instruction (rs1 [19:15], rs2 [24:20], funct3 [14:12], funct7[5] = bit 30, opcode [6:0])
- rd_IDEX  in  5  destination register
- branch_IDEX, memRead_IDEX, mem2reg_IDEX, memWrite_IDEX, ALUSrc_IDEX, RegWrite_IDEX  in  1 each  control bits
- ALUOp_IDEX  in  2  00 = add, 01 = branch compare, 10 = funct-decoded
- rd_MEMWB  in  5  destination register in WB
- RegWrite_MEMWB  in  1  WB writes a register
- wb_data  in  32  final write-back value (ALU result or load data)
- flush_EX  in  1  turn the instruction now in EX into a bubble
- branch_taken_EX  out  1  combinational; branch resolved taken
- branch_target_EX  out  32  combinational; PC_IDEX + imm_IDEX
- alu_result_EXMEM  out  32  registered ALU result
- write_data_EXMEM  out  32  registered, forwarded rs2 (store data)
- rd_EXMEM  out  5  registered destination register
- memRead_EXMEM, memWrite_EXMEM, mem2reg_EXMEM, RegWrite_EXMEM  out  1 each  registered control bits

Behaviour:
- Reset: every EX/MEM output is 0 asynchronously while rst_n = 0. Combinational outputs follow their inputs during reset.
- Latency: 1 cycle. Values computed from ID/EX inputs in cycle N appear on EX/MEM outputs after the rising edge ending cycle N.
- Forwarding for operand A (rs1) and operand B (rs2):
  - EX/MEM hit: RegWrite_EXMEM = 1 and rd_EXMEM ≠ 0 and rd_EXMEM = rs → select alu_result_EXMEM. This source has priority.
  - MEM/WB hit: else if RegWrite_MEMWB = 1 and rd_MEMWB ≠ 0 and rd_MEMWB = rs → select wb_data.
  - Otherwise select the register-file value.
  - x0 is never forwarded.
  - Load-use stalls are owned by the hazard unit; this block does not detect them.
- ALU operand A is forwarded rs1. ALU operand B is imm_IDEX when ALUSrc_IDEX = 1, else forwarded rs2.
- write_data_EXMEM always captures forwarded rs2, never the immediate.
- ALU control:
  - ALUOp 00: ADD.
  - ALUOp 01: SUB (result unused; compare is done separately).
  - ALUOp 10, funct3 decode:
    - 000: ADD; SUB only when opcode bit 5 = 1 (R-type) and bit 30 = 1.
    - 001: SLL.
    - 010: SLT (signed).
    - 011: SLTU.
    - 100: XOR.
    - 101: SRL, or SRA when bit 30 = 1 (applies to both R-type and I-type).
    - 110: OR.
    - 111: AND.
  - ALUOp 11: ADD (reserved).
- Arithmetic rules: add/sub wrap modulo 2^32. Shift amount is operand B[4:0]. SLT/SLTU yield 32'h0000_0001 or 0.
- Branch resolution (forwarded rs1 vs forwarded rs2, funct3):
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 are never taken.
  - branch_taken_EX = branch_IDEX & condition & ~flush_EX.
- branch_target_EX = PC_IDEX + imm_IDEX, wrapping modulo 2^32.
- Flush: when flush_EX = 1 at the clock edge, the EX/MEM control bits load 0 and rd_EXMEM loads 0. Data fields are don't-care; they load the normal values.
- A branch itself writes no register. Its EX/MEM entry carries RegWrite = 0 and mem bits = 0 as decoded upstream.
- Simultaneous hits: EX/MEM and MEM/WB both match → EX/MEM wins. rs1 = rs2 with a hit → both operands forward.
- Reset mid-operation: the in-flight EX/MEM entry is discarded, with all outputs 0 immediately.

Test Plan:
- Reset → all EX/MEM outputs 0. Release reset, feed ADD x3,x1,x2 with rd1 = 5, rd2 = 7 → next edge: alu_result_EXMEM = 12, rd_EXMEM = 3, RegWrite_EXMEM = 1.
- Back-to-back dependency:
  - ADD x3 = 12 in EX/MEM, then SUB x4,x3,x1 with register-file x3 = 0, x1 = 5 → result 7 (EX/MEM forward).
  - Same case with MEM/WB also writing x3 = 99 → still 7 (priority).
- Writes to x0: RegWrite_EXMEM = 1 with rd_EXMEM = 0 holding 55, next instruction reads x0 with register-file value 0 → operand 0, no forward.
- Branches:
  - BLT with rs1 = 32'hFFFF_FFFF, rs2 = 1, PC = 0x100, imm = −8 → branch_taken_EX = 1, target = 0xF8.
  - Same operands as BLTU → branch_taken_EX = 0.
- SRAI x5,x6,4 (ALUSrc = 1, bit 30 = 1) with x6 = 32'h8000_0000 → 32'hF800_0000. Store with ALUSrc = 1, imm = 8 → alu_result = base + 8, write_data_EXMEM = forwarded rs2.
- flush_EX = 1 during a taken BEQ plus a following ADD → branch_taken_EX forced 0, EX/MEM controls and rd all 0. Assert rst_n = 0 mid-stream → all EX/MEM outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and the EX/MEM register.
// Branch outcome and target leave combinationally; everything else is registered.
module ex_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] rf_i,
  input  logic            rw_exmem_i,
  input  logic [4:0]      rd_exmem_i,
  input  logic [XLEN-1:0] alu_exmem_i,
  input  logic            rw_memwb_i,
  input  logic [4:0]      rd_memwb_i,
  input  logic [XLEN-1:0] wb_i,
  output logic [XLEN-1:0] val_o
);
  // EX/MEM is the younger producer, so it outranks MEM/WB; x0 never forwards.
  always_comb begin
    val_o = rf_i;
    if (rw_exmem_i && rd_exmem_i != 5'd0 && rd_exmem_i == rs_i)      val_o = alu_exmem_i;
    else if (rw_memwb_i && rd_memwb_i != 5'd0 && rd_memwb_i == rs_i) val_o = wb_i;
  end
endmodule

module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] read_data1_IDEX,
  input  logic [XLEN-1:0] read_data2_IDEX,
  input  logic [XLEN-1:0] PC_IDEX,
  input  logic [XLEN-1:0] imm_IDEX,
  input  logic [31:0]     instruc_IDEX,
  input  logic [4:0]      rd_IDEX,
  input  logic            branch_IDEX,
  input  logic            memRead_IDEX,
  input  logic            mem2reg_IDEX,
  input  logic            memWrite_IDEX,
  input  logic            ALUSrc_IDEX,
  input  logic            RegWrite_IDEX,
  input  logic [1:0]      ALUOp_IDEX,
  input  logic [4:0]      rd_MEMWB,
  input  logic            RegWrite_MEMWB,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush_EX,
  output logic            branch_taken_EX,
  output logic [XLEN-1:0] branch_target_EX,
  output logic [XLEN-1:0] alu_result_EXMEM,
  output logic [XLEN-1:0] write_data_EXMEM,
  output logic [4:0]      rd_EXMEM,
  output logic            memRead_EXMEM,
  output logic            memWrite_EXMEM,
  output logic            mem2reg_EXMEM,
  output logic            RegWrite_EXMEM
);
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            mr;
    logic            mw;
    logic            m2r;
    logic            rw;
  } exmem_t;

  exmem_t exmem_q, exmem_d;

  logic [2:0] funct3;
  logic       b30, rtype;
  assign funct3 = instruc_IDEX[14:12];
  assign b30    = instruc_IDEX[30];
  assign rtype  = instruc_IDEX[5];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruc_IDEX[31], instruc_IDEX[29:25], instruc_IDEX[11:6],
                               instruc_IDEX[4:0]};

  // Operand 0 = rs1, operand 1 = rs2
  logic [1:0][4:0]      rs;
  logic [1:0][XLEN-1:0] rf, fwd;
  assign rs = {instruc_IDEX[24:20], instruc_IDEX[19:15]};
  assign rf = {read_data2_IDEX, read_data1_IDEX};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    ex_fwd_mux #(.XLEN(XLEN)) u_fwd (
      .rs_i        (rs[g]),
      .rf_i        (rf[g]),
      .rw_exmem_i  (exmem_q.rw),
      .rd_exmem_i  (exmem_q.rd),
      .alu_exmem_i (exmem_q.alu),
      .rw_memwb_i  (RegWrite_MEMWB),
      .rd_memwb_i  (rd_MEMWB),
      .wb_i        (wb_data),
      .val_o       (fwd[g])
    );
  end

  logic [XLEN-1:0] op_a, op_b, alu_res;
  assign op_a = fwd[0];
  assign op_b = ALUSrc_IDEX ? imm_IDEX : fwd[1];

  alu_op_e alu_op;
  always_comb begin
    alu_op = ALU_ADD;
    case (ALUOp_IDEX)
      2'b01: alu_op = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000: alu_op = (rtype && b30) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = b30 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  logic lt_s, lt_u, eq;
  assign lt_s = $signed(fwd[0]) < $signed(fwd[1]);
  assign lt_u = fwd[0] < fwd[1];
  assign eq   = fwd[0] == fwd[1];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch compare works on the forwarded registers, independent of ALUSrc.
  logic cond;
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000: cond = eq;
      3'b001: cond = ~eq;
      3'b100: cond = lt_s;
      3'b101: cond = ~lt_s;
      3'b110: cond = lt_u;
      3'b111: cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken_EX  = branch_IDEX & cond & ~flush_EX;
  assign branch_target_EX = PC_IDEX + imm_IDEX;

  always_comb begin
    exmem_d       = '0;
    exmem_d.alu   = alu_res;
    exmem_d.wdata = fwd[1];
    exmem_d.rd    = flush_EX ? 5'd0 : rd_IDEX;
    exmem_d.mr    = memRead_IDEX  & ~flush_EX;
    exmem_d.mw    = memWrite_IDEX & ~flush_EX;
    exmem_d.m2r   = mem2reg_IDEX  & ~flush_EX;
    exmem_d.rw    = RegWrite_IDEX & ~flush_EX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign alu_result_EXMEM = exmem_q.alu;
  assign write_data_EXMEM = exmem_q.wdata;
  assign rd_EXMEM         = exmem_q.rd;
  assign memRead_EXMEM    = exmem_q.mr;
  assign memWrite_EXMEM   = exmem_q.mw;
  assign mem2reg_EXMEM    = exmem_q.m2r;
  assign RegWrite_EXMEM   = exmem_q.rw;
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against an instruction-level reference model.
module tb_ex_stage;
  typedef struct {
    logic [31:0] rd1, rd2, pc, imm, instr, wb;
    logic [4:0]  rd, rd_wb;
    logic        br, mr, m2r, mw, src, rw, rw_wb, flush;
    logic [1:0]  aluop;
  } stim_t;

  typedef struct {
    logic [31:0] alu, wdata;
    logic [4:0]  rd;
    logic        mr, mw, m2r, rw;
  } exm_t;

  logic clk = 1'b0, rst_n = 1'b0;
  stim_t s;
  exm_t  mx;
  int checks = 0, errors = 0;

  logic        taken;
  logic [31:0] target, alu_o, wd_o;
  logic [4:0]  rd_o;
  logic        mr_o, mw_o, m2r_o, rw_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .read_data1_IDEX(s.rd1), .read_data2_IDEX(s.rd2), .PC_IDEX(s.pc), .imm_IDEX(s.imm),
    .instruc_IDEX(s.instr), .rd_IDEX(s.rd),
    .branch_IDEX(s.br), .memRead_IDEX(s.mr), .mem2reg_IDEX(s.m2r), .memWrite_IDEX(s.mw),
    .ALUSrc_IDEX(s.src), .RegWrite_IDEX(s.rw), .ALUOp_IDEX(s.aluop),
    .rd_MEMWB(s.rd_wb), .RegWrite_MEMWB(s.rw_wb), .wb_data(s.wb), .flush_EX(s.flush),
    .branch_taken_EX(taken), .branch_target_EX(target),
    .alu_result_EXMEM(alu_o), .write_data_EXMEM(wd_o), .rd_EXMEM(rd_o),
    .memRead_EXMEM(mr_o), .memWrite_EXMEM(mw_o), .mem2reg_EXMEM(m2r_o), .RegWrite_EXMEM(rw_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of architectural register r as the instruction in EX should see it.
  function automatic logic [31:0] see(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (mx.rw && mx.rd == r) return mx.alu;
    if (s.rw_wb && s.rd_wb == r) return s.wb;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [2:0] f3;
    sh = int'(b[4:0]);
    f3 = s.instr[14:12];
    if (s.aluop == 2'b01) return a - b;
    if (s.aluop != 2'b10) return a + b;
    case (f3)
      3'd0: return (s.instr[5] && s.instr[30]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (!s.instr[30]) return a >> sh;
        return 32'(longint'(int'(a)) / (longint'(1) << sh) - ((int'(a) < 0 && (a & ((32'd1 << sh) - 1)) != 0) ? 1 : 0));
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b);
    logic c;
    case (s.instr[14:12])
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = int'(a) < int'(b);
      3'd5: c = int'(a) >= int'(b);
      3'd6: c = longint'({32'd0, a}) < longint'({32'd0, b});
      3'd7: c = longint'({32'd0, a}) >= longint'({32'd0, b});
      default: c = 1'b0;
    endcase
    return s.br && c && !s.flush;
  endfunction

  task automatic step(input string tag);
    logic [31:0] a, b;
    exm_t nx;
    a = see(s.instr[19:15], s.rd1);
    b = see(s.instr[24:20], s.rd2);
    nx.alu   = ref_alu(a, s.src ? s.imm : b);
    nx.wdata = b;
    nx.rd    = s.flush ? 5'd0 : s.rd;
    nx.mr    = s.mr  && !s.flush;
    nx.mw    = s.mw  && !s.flush;
    nx.m2r   = s.m2r && !s.flush;
    nx.rw    = s.rw  && !s.flush;
    #1;
    chk({tag, ".taken"},  {31'd0, taken}, {31'd0, ref_taken(a, b)});
    chk({tag, ".target"}, target, s.pc + s.imm);
    @(posedge clk); #1;
    chk({tag, ".alu"},   alu_o, nx.alu);
    chk({tag, ".wdata"}, wd_o, nx.wdata);
    chk({tag, ".rd"},    {27'd0, rd_o}, {27'd0, nx.rd});
    chk({tag, ".ctl"},   {28'd0, mr_o, mw_o, m2r_o, rw_o}, {28'd0, nx.mr, nx.mw, nx.m2r, nx.rw});
    mx = nx;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu"},   alu_o, 32'd0);
    chk({tag, ".wdata"}, wd_o, 32'd0);
    chk({tag, ".rd"},    {27'd0, rd_o}, 32'd0);
    chk({tag, ".ctl"},   {28'd0, mr_o, mw_o, m2r_o, rw_o}, 32'd0);
  endtask

  // kind: 0 R-type, 1 I-type ALU, 2 load, 3 store, 4 branch
  task automatic setup(input int kind, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic b30,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm);
    logic [6:0] opc;
    case (kind)
      0: opc = 7'b0110011;
      1: opc = 7'b0010011;
      2: opc = 7'b0000011;
      3: opc = 7'b0100011;
      default: opc = 7'b1100011;
    endcase
    s.instr = {1'b0, b30, 5'd0, rs2, rs1, f3, 5'd0, opc};
    s.rd1 = v1; s.rd2 = v2; s.imm = imm; s.rd = rd;
    s.br  = (kind == 4);
    s.mr  = (kind == 2);
    s.m2r = (kind == 2);
    s.mw  = (kind == 3);
    s.src = (kind == 1 || kind == 2 || kind == 3);
    s.rw  = (kind <= 2);
    s.aluop = (kind <= 1) ? 2'b10 : (kind == 4) ? 2'b01 : 2'b00;
    s.rd_wb = 5'd0; s.rw_wb = 1'b0; s.wb = 32'd0; s.flush = 1'b0;
  endtask

  initial begin
    s = '{default: '0};
    mx = '{default: '0};
    s.pc = 32'h40;
    #3;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    setup(0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0);
    step("add");
    chk("add.val", alu_o, 32'd12);
    setup(0, 5'd3, 5'd1, 5'd4, 3'd0, 1'b1, 32'd0, 32'd5, 32'd0);
    step("sub_fwd");
    chk("sub_fwd.val", alu_o, 32'd7);

    setup(0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0);
    step("add2");
    setup(0, 5'd3, 5'd1, 5'd4, 3'd0, 1'b1, 32'd0, 32'd5, 32'd0);
    s.rd_wb = 5'd3; s.rw_wb = 1'b1; s.wb = 32'd99;
    step("sub_prio");
    chk("sub_prio.val", alu_o, 32'd7);

    setup(0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd55, 32'd0, 32'd0);
    step("wr_x0");
    setup(0, 5'd0, 5'd0, 5'd7, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    step("rd_x0");
    chk("rd_x0.val", alu_o, 32'd0);

    setup(4, 5'd8, 5'd9, 5'd0, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    s.pc = 32'h100;
    #1;
    chk("blt.taken_k", {31'd0, taken}, 32'd1);
    chk("blt.target_k", target, 32'hF8);
    step("blt");
    setup(4, 5'd8, 5'd9, 5'd0, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    #1;
    chk("bltu.taken_k", {31'd0, taken}, 32'd0);
    step("bltu");

    setup(1, 5'd6, 5'd0, 5'd5, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404);
    step("srai");
    chk("srai.val", alu_o, 32'hF800_0000);
    setup(3, 5'd10, 5'd5, 5'd0, 3'd2, 1'b0, 32'h1000, 32'd0, 32'd8);
    step("store");
    chk("store.addr", alu_o, 32'h1008);
    chk("store.data", wd_o, 32'hF800_0000);

    setup(4, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd4, 32'd4, 32'd16);
    s.flush = 1'b1;
    #1;
    chk("flush_beq.taken_k", {31'd0, taken}, 32'd0);
    step("flush_beq");
    setup(0, 5'd1, 5'd2, 5'd9, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    s.flush = 1'b1;
    step("flush_add");
    chk("flush_add.rw", {31'd0, rw_o}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      setup(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)),
            ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)), $urandom);
      s.pc = $urandom;
      s.rd_wb = 5'($urandom_range(0, 3)); s.rw_wb = 1'($urandom); s.wb = $urandom;
      s.flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    setup(0, 5'd1, 5'd2, 5'd3, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'd0);
    step("pre_rst");
    chk("pre_rst.rw", {31'd0, rw_o}, 32'd1);
    setup(2, 5'd3, 5'd0, 5'd4, 3'd2, 1'b0, 32'd0, 32'd0, 32'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    mx = '{default: '0};
    @(negedge clk); rst_n = 1'b1;
    step("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
